// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipelined control unit: instruction widths,
// class and sub-op encodings, ALU op codes, pc_mux / reg_write_mux codes,
// the staged control structs with their BUBBLE constants, and small helpers
// for branch resolution and register-hazard matching.
// Optional feature macro used by the files that import this package:
// PIPE_CTRL_RAW_STALL_EN (register RAW hazard stall).
package pipe_ctrl_pkg;

   localparam int INSTR_W  = 19;
   localparam int ALU_OP_W = 3;

   localparam logic [1:0] CLS_MEM   = 2'b00;
   localparam logic [1:0] CLS_SHIFT = 2'b01;
   localparam logic [1:0] CLS_BR    = 2'b10;
   localparam logic [1:0] CLS_CTL   = 2'b11;

   localparam logic [1:0] MEM_LD = 2'b00;
   localparam logic [1:0] MEM_ST = 2'b01;

   localparam logic [1:0] BR_BZ  = 2'b00;
   localparam logic [1:0] BR_BNZ = 2'b01;
   localparam logic [1:0] BR_BC  = 2'b10;

   localparam logic [1:0] CTL_JMP = 2'b00;
   localparam logic [1:0] CTL_JSB = 2'b01;
   localparam logic [1:0] CTL_RET = 2'b10;

   localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALU_OP_W-1:0] ALU_ADC = 3'b001;
   localparam logic [ALU_OP_W-1:0] ALU_SBC = 3'b011;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   localparam logic [1:0] PC_RETURN = 2'b11;

   localparam logic [1:0] RWM_ALU   = 2'b00;
   localparam logic [1:0] RWM_SHIFT = 2'b01;
   localparam logic [1:0] RWM_MEM   = 2'b10;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] reg_write_mux;
   } ctrl_wb_t;

   // The ID/EX register carries the WB controls along with the EX controls.
   typedef struct packed {
      logic [ALU_OP_W-1:0] alu_op;
      logic                alu_in_mux;
      logic                alu_use_carry;
      logic                select_c;
      logic                select_z;
      logic                write_c;
      logic                write_z;
      logic                mem_write;
      ctrl_wb_t            wb;
   } ctrl_ex_t;

   typedef struct packed {
      logic       reg_b_mux;
      logic       branch;
      logic [1:0] br_cond;
      logic       jmp;
      logic       jsb;
      logic       ret;
   } ctrl_id_t;

   localparam ctrl_ex_t BUBBLE    = '0;
   localparam ctrl_id_t ID_BUBBLE = '0;

   // BZ/BNZ test Z, BC/BNC test C.
   function automatic logic branch_taken(input logic [1:0] cond, input logic c, input logic z);
      case (cond)
         BR_BZ:   return z;
         BR_BNZ:  return !z;
         BR_BC:   return c;
         default: return !c;
      endcase
   endfunction

   // r0 never creates a dependency.
   function automatic logic raw_match(input logic en, input logic [2:0] src,
                                      input logic ex_we, input logic [2:0] ex_rd,
                                      input logic wb_we, input logic [2:0] wb_rd);
      return en && (src != 3'd0) && ((ex_we && (src == ex_rd)) || (wb_we && (src == wb_rd)));
   endfunction

endpackage

// File: rtl/pipe_controller_if.sv
// pipe_controller_if
// Bundle between the control unit and the pipelined datapath.
//   master (control unit): reads if_id_instruction, C, Z; drives all controls.
//   slave  (datapath)    : drives if_id_instruction, C, Z; reads all controls.
// ID controls : reg_B_mux, pc_mux, push, pop, flush, stall (combinational).
// EX controls : alu_op, alu_in_mux, alu_use_carry, select_c/z, write_c/z, mem_write.
// WB controls : reg_write, reg_write_mux.
interface pipe_controller_if;
   import pipe_ctrl_pkg::*;

   logic [INSTR_W-1:0]  if_id_instruction;
   logic                C;
   logic                Z;
   logic                reg_B_mux;
   logic [1:0]          pc_mux;
   logic                push;
   logic                pop;
   logic                flush;
   logic                stall;
   logic [ALU_OP_W-1:0] alu_op;
   logic                alu_in_mux;
   logic                alu_use_carry;
   logic                select_c;
   logic                select_z;
   logic                write_c;
   logic                write_z;
   logic                mem_write;
   logic                reg_write;
   logic [1:0]          reg_write_mux;

   modport master (
      input  if_id_instruction, C, Z,
      output reg_B_mux, pc_mux, push, pop, flush, stall,
             alu_op, alu_in_mux, alu_use_carry, select_c, select_z,
             write_c, write_z, mem_write, reg_write, reg_write_mux
   );

   modport slave (
      output if_id_instruction, C, Z,
      input  reg_B_mux, pc_mux, push, pop, flush, stall,
             alu_op, alu_in_mux, alu_use_carry, select_c, select_z,
             write_c, write_z, mem_write, reg_write, reg_write_mux
   );

endinterface

// File: rtl/pipe_ctrl_decode.sv
// pipe_ctrl_decode
// Purely combinational decode of the ID-stage instruction into ID, EX and
// WB control fields. Anything not recognised (NOP, reserved) is a bubble.
// Ports: instr (in), id_ctrl / ex_ctrl (out); with PIPE_CTRL_RAW_STALL_EN
// also the source register numbers, their enables and rd.
module pipe_ctrl_decode
   import pipe_ctrl_pkg::*;
(
   input  logic [INSTR_W-1:0] instr,
`ifdef PIPE_CTRL_RAW_STALL_EN
   output logic               src_a_en,
   output logic               src_b_en,
   output logic [2:0]         src_a,
   output logic [2:0]         src_b,
   output logic [2:0]         rd,
`endif
   output ctrl_id_t           id_ctrl,
   output ctrl_ex_t           ex_ctrl
);

   // Register/offset fields are consumed by the datapath directly.
   logic unused_bits;
   assign unused_bits = ^instr[13:0];

   // Start from a bubble and switch on only what the instruction needs.
   always_comb begin
      id_ctrl = ID_BUBBLE;
      ex_ctrl = BUBBLE;
`ifdef PIPE_CTRL_RAW_STALL_EN
      src_a_en = 1'b0;
      src_b_en = 1'b0;
      rd       = instr[13:11];
      src_a    = instr[10:8];
`endif
      if (!instr[18]) begin
         ex_ctrl.alu_in_mux       = instr[17];
         ex_ctrl.alu_op           = instr[16:14];
         ex_ctrl.alu_use_carry    = (instr[16:14] == ALU_ADC) || (instr[16:14] == ALU_SBC);
         ex_ctrl.write_z          = 1'b1;
         ex_ctrl.write_c          = !instr[16];
         ex_ctrl.wb.reg_write     = 1'b1;
         ex_ctrl.wb.reg_write_mux = RWM_ALU;
`ifdef PIPE_CTRL_RAW_STALL_EN
         src_a_en = 1'b1;
         src_b_en = !instr[17];
`endif
      end else begin
         case (instr[17:16])
            CLS_MEM: begin
               case (instr[15:14])
                  MEM_LD: begin
                     ex_ctrl.alu_op           = ALU_ADD;
                     ex_ctrl.alu_in_mux       = 1'b1;
                     ex_ctrl.wb.reg_write     = 1'b1;
                     ex_ctrl.wb.reg_write_mux = RWM_MEM;
`ifdef PIPE_CTRL_RAW_STALL_EN
                     src_a_en = 1'b1;
`endif
                  end
                  MEM_ST: begin
                     ex_ctrl.alu_op     = ALU_ADD;
                     ex_ctrl.alu_in_mux = 1'b1;
                     ex_ctrl.mem_write  = 1'b1;
                     id_ctrl.reg_b_mux  = 1'b1;
`ifdef PIPE_CTRL_RAW_STALL_EN
                     src_a_en = 1'b1;
                     src_b_en = 1'b1;
`endif
                  end
                  default: ;
               endcase
            end
            CLS_SHIFT: begin
               ex_ctrl.select_c         = 1'b1;
               ex_ctrl.select_z         = 1'b1;
               ex_ctrl.write_c          = 1'b1;
               ex_ctrl.write_z          = 1'b1;
               ex_ctrl.wb.reg_write     = 1'b1;
               ex_ctrl.wb.reg_write_mux = RWM_SHIFT;
`ifdef PIPE_CTRL_RAW_STALL_EN
               src_a_en = 1'b1;
`endif
            end
            CLS_BR: begin
               id_ctrl.branch  = 1'b1;
               id_ctrl.br_cond = instr[15:14];
            end
            default: begin
               case (instr[15:14])
                  CTL_JMP: id_ctrl.jmp = 1'b1;
                  CTL_JSB: id_ctrl.jsb = 1'b1;
                  CTL_RET: id_ctrl.ret = 1'b1;
                  default: ;
               endcase
            end
         endcase
      end
`ifdef PIPE_CTRL_RAW_STALL_EN
      src_b = id_ctrl.reg_b_mux ? instr[13:11] : instr[7:5];
`endif
   end

endmodule

// File: rtl/pipe_controller.sv
// pipe_controller
// Control unit for the pipelined datapath. Decodes the ID instruction,
// resolves branches/jumps, generates flush and the post-flush kill, detects
// the flag hazard and stalls, and stages EX/WB controls through ID/EX and
// EX/WB registers.
// Ports: clk, reset (async, active-high), bus (pipe_controller_if.master).
// Optional: PIPE_CTRL_RAW_STALL_EN adds register RAW hazard stalls.
module pipe_controller
   import pipe_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   pipe_controller_if.master   bus
);

   ctrl_id_t   dec_id;
   ctrl_ex_t   dec_ex;
   ctrl_ex_t   idex_d, idex_q;
   ctrl_wb_t   exwb_d, exwb_q;
   logic       kill_d, kill_q;
   logic       flag_hazard, raw_hazard;
   logic       reg_b_mux, push, pop, flush, stall;
   logic [1:0] pc_mux;

`ifdef PIPE_CTRL_RAW_STALL_EN
   logic       src_a_en, src_b_en;
   logic [2:0] src_a, src_b, dec_rd;
   logic [2:0] ex_rd_d, ex_rd_q, wb_rd_d, wb_rd_q;
`endif

   pipe_ctrl_decode u_decode (
      .instr    (bus.if_id_instruction),
`ifdef PIPE_CTRL_RAW_STALL_EN
      .src_a_en (src_a_en),
      .src_b_en (src_b_en),
      .src_a    (src_a),
      .src_b    (src_b),
      .rd       (dec_rd),
`endif
      .id_ctrl  (dec_id),
      .ex_ctrl  (dec_ex)
   );

   // A branch must wait while the instruction ahead of it in EX still
   // writes the flag it tests; the optional RAW check covers register sources.
   always_comb begin
      flag_hazard = dec_id.branch && (dec_id.br_cond[1] ? idex_q.write_c : idex_q.write_z);
`ifdef PIPE_CTRL_RAW_STALL_EN
      raw_hazard = raw_match(src_a_en, src_a, idex_q.wb.reg_write, ex_rd_q, exwb_q.reg_write, wb_rd_q) ||
                   raw_match(src_b_en, src_b, idex_q.wb.reg_write, ex_rd_q, exwb_q.reg_write, wb_rd_q);
      ex_rd_d    = dec_rd;
      wb_rd_d    = ex_rd_q;
`else
      raw_hazard = 1'b0;
`endif
   end

   // ID-stage outputs and ID/EX load. kill beats stall beats flush; a killed
   // or stalled instruction sends a bubble down the pipe instead of itself.
   always_comb begin
      reg_b_mux = 1'b0;
      pc_mux    = PC_SEQ;
      push      = 1'b0;
      pop       = 1'b0;
      flush     = 1'b0;
      stall     = 1'b0;
      idex_d    = BUBBLE;
      if (!kill_q) begin
         reg_b_mux = dec_id.reg_b_mux;
         if (flag_hazard || raw_hazard) begin
            stall = 1'b1;
         end else begin
            idex_d = dec_ex;
            if (dec_id.branch && branch_taken(dec_id.br_cond, bus.C, bus.Z)) begin
               pc_mux = PC_BRANCH;
               flush  = 1'b1;
            end else if (dec_id.jmp) begin
               pc_mux = PC_JUMP;
               flush  = 1'b1;
            end else if (dec_id.jsb) begin
               pc_mux = PC_JUMP;
               push   = 1'b1;
               flush  = 1'b1;
            end else if (dec_id.ret) begin
               pc_mux = PC_RETURN;
               pop    = 1'b1;
               flush  = 1'b1;
            end
         end
      end
      kill_d = flush;
      exwb_d = idex_q.wb;
   end

   // Stage registers; reset throws away everything in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idex_q <= BUBBLE;
         exwb_q <= '0;
         kill_q <= 1'b0;
      end else begin
         idex_q <= idex_d;
         exwb_q <= exwb_d;
         kill_q <= kill_d;
      end
   end

`ifdef PIPE_CTRL_RAW_STALL_EN
   // Destination tracking; stale rd behind a bubble is harmless since reg_write is 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_rd_q <= 3'd0;
         wb_rd_q <= 3'd0;
      end else begin
         ex_rd_q <= ex_rd_d;
         wb_rd_q <= wb_rd_d;
      end
   end
`endif

   assign bus.reg_B_mux     = reg_b_mux;
   assign bus.pc_mux        = pc_mux;
   assign bus.push          = push;
   assign bus.pop           = pop;
   assign bus.flush         = flush;
   assign bus.stall         = stall;
   assign bus.alu_op        = idex_q.alu_op;
   assign bus.alu_in_mux    = idex_q.alu_in_mux;
   assign bus.alu_use_carry = idex_q.alu_use_carry;
   assign bus.select_c      = idex_q.select_c;
   assign bus.select_z      = idex_q.select_z;
   assign bus.write_c       = idex_q.write_c;
   assign bus.write_z       = idex_q.write_z;
   assign bus.mem_write     = idex_q.mem_write;
   assign bus.reg_write     = exwb_q.reg_write;
   assign bus.reg_write_mux = exwb_q.reg_write_mux;

endmodule
